// File: rtl/inst_axi_read_bridge.sv
// rtl/inst_axi_read_bridge.sv - instruction-fetch SRAM-like to AXI single-beat read bridge
module inst_axi_read_bridge #(
  parameter int         OUTSTANDING = 2,
  parameter logic [3:0] AXI_ID      = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int            CW      = $clog2(OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(OUTSTANDING);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic          arvalid_q;
  logic [31:0]   araddr_q;
  logic [2:0]    arsize_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] drop;
  logic          r_done;
  logic          data_ok_q;
  logic [31:0]   rdata_q;

  // Write-side and response-status inputs carry no meaning for a fetch-only bridge.
  logic unused_inputs;
  assign unused_inputs = ^{inst_wstrb, inst_wdata, rid, rresp};

  // A beat only completes a request if one is outstanding; stray beats are ignored.
  assign r_done = rvalid & rlast & (cnt != '0);

  // The AR register can take a new request when empty or when it drains this cycle.
  assign inst_addr_ok = inst_req & ~inst_wr & ~inst_cancel & (cnt < CNT_MAX)
                      & (~arvalid_q | arready);

  assign arid         = AXI_ID;
  assign araddr       = araddr_q;
  assign arlen        = 8'd0;
  assign arsize       = arsize_q;
  assign arburst      = 2'b01;
  assign arvalid      = arvalid_q;
  assign rready       = 1'b1;
  assign inst_data_ok = data_ok_q;
  assign inst_rdata   = rdata_q;

  // Outstanding count after this cycle's acceptance and completion.
  always_comb begin
    cnt_next = cnt;
    if (inst_addr_ok && !r_done) begin
      cnt_next = cnt + ONE;
    end else if (!inst_addr_ok && r_done) begin
      cnt_next = cnt - ONE;
    end
  end

  // AR register: load on acceptance, clear on handshake; address held until then.
  always_ff @(posedge clk) begin
    if (reset) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arsize_q  <= '0;
    end else if (inst_addr_ok) begin
      arvalid_q <= 1'b1;
      araddr_q  <= inst_addr;
      arsize_q  <= {1'b0, inst_size};
    end else if (arready) begin
      arvalid_q <= 1'b0;
    end
  end

  // Outstanding and discard counters; a cancel marks everything in flight as stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      drop <= '0;
    end else begin
      cnt <= cnt_next;
      if (inst_cancel) begin
        drop <= cnt_next;
      end else if (r_done && (drop != '0)) begin
        drop <= drop - ONE;
      end
    end
  end

  // Response register: forward only beats that belong to live requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else if (r_done && (drop == '0) && !inst_cancel) begin
      data_ok_q <= 1'b1;
      rdata_q   <= rdata;
    end else begin
      data_ok_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_axi_read_bridge.sv
// tb/tb_inst_axi_read_bridge.sv - scoreboard bench for inst_axi_read_bridge
module tb_inst_axi_read_bridge;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_cancel;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  inst_axi_read_bridge #(.OUTSTANDING(2), .AXI_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .inst_cancel(inst_cancel),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rbeat_t;

  rbeat_t      rq[$];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_dok = 0;
  int          cyc   = 0;
  int          lat   = 2;
  logic        ar_en = 1'b0;
  logic        last_ok;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h3C08_0001;
    return {a[15:0] ^ 16'hA5C3, a[31:16]} + 32'h0000_1001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, want);
    end
  endtask

  // One clock cycle: slave drives, scoreboard pushes on accept, outputs checked after the edge.
  task automatic cycle();
    logic        hs_ar;
    logic        hs_r;
    logic        pend_ar;
    logic [31:0] ar_addr_s;
    arready = ar_en;
    if (rq.size() > 0 && rq[0].due <= cyc + 1) begin
      rvalid = 1'b1;
      rlast  = 1'b1;
      rdata  = mem(rq[0].addr);
    end else begin
      rvalid = 1'b0;
      rlast  = 1'b0;
      rdata  = 32'h0BAD_0BAD;
    end
    #1;
    last_ok = inst_addr_ok;
    if (inst_addr_ok && !reset) exp_q.push_back(mem(inst_addr));
    if (inst_cancel && !reset) exp_q.delete();
    hs_ar     = arvalid & arready;
    hs_r      = rvalid;
    pend_ar   = arvalid & ~arready & ~reset;
    ar_addr_s = araddr;
    @(posedge clk);
    cyc++;
    if (hs_r) void'(rq.pop_front());
    if (hs_ar) rq.push_back('{ar_addr_s, cyc + lat});
    @(negedge clk);
    if (pend_ar) begin
      chk("ar_hold_valid", {31'd0, arvalid}, 32'd1);
      chk("ar_hold_addr", araddr, ar_addr_s);
    end
    if (inst_data_ok) begin
      n_dok++;
      if (exp_q.size() == 0) chk("spurious_data_ok", {31'd0, inst_data_ok}, 32'd0);
      else chk("rdata", inst_rdata, exp_q.pop_front());
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] a, output int waits);
    waits       = 0;
    inst_req    = 1'b1;
    inst_wr     = 1'b0;
    inst_addr   = a;
    inst_size   = 2'd2;
    cycle();
    while (!last_ok && waits < 20) begin
      waits++;
      cycle();
    end
    inst_req = 1'b0;
    chk(tag, {31'd0, last_ok}, 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n           = 0;
    inst_req    = 1'b0;
    inst_cancel = 1'b0;
    inst_wr     = 1'b0;
    while ((exp_q.size() != 0 || rq.size() != 0) && n < 40) begin
      cycle();
      n++;
    end
    cycle();
    cycle();
    chk(tag, exp_q.size() + rq.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int d0;
    reset = 1'b1; inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2;
    inst_wstrb = 4'h0; inst_addr = '0; inst_wdata = '0; inst_cancel = 1'b0;
    arready = 1'b0; rid = 4'h0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arsize", {29'd0, arsize}, 32'd0);
    chk("rst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("rst_rdata", inst_rdata, 32'd0);
    chk("rst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("arlen", {24'd0, arlen}, 32'd0);
    chk("arburst", {30'd0, arburst}, 32'd1);
    chk("arid", {28'd0, arid}, 32'd0);
    chk("rready", {31'd0, rready}, 32'd1);
    reset = 1'b0;
    cycle();

    // Single fetch with arready at T+1 and the beat at T+3.
    ar_en = 1'b0; lat = 2;
    fetch("t1_accept", 32'hBFC0_0000, w);
    chk("t1_accept_at_T", w, 0);
    chk("t1_arvalid", {31'd0, arvalid}, 32'd1);
    chk("t1_araddr", araddr, 32'hBFC0_0000);
    chk("t1_arsize", {29'd0, arsize}, 32'd2);
    ar_en = 1'b1;
    cycle();
    ar_en = 1'b0;
    chk("t1_ar_cleared", {31'd0, arvalid}, 32'd0);
    cycle();
    chk("t1_dok_T3", {31'd0, inst_data_ok}, 32'd0);
    cycle();
    chk("t1_dok_T4", {31'd0, inst_data_ok}, 32'd1);
    chk("t1_rdata_T4", inst_rdata, 32'h3C08_0001);
    cycle();
    chk("t1_dok_T5", {31'd0, inst_data_ok}, 32'd0);
    drain("t1_drain");

    // Back-to-back fetches; the third waits for the first completion.
    ar_en = 1'b1; lat = 2;
    fetch("t2_accept0", 32'h0000_0000, w);
    chk("t2_wait0", w, 0);
    fetch("t2_accept1", 32'h0000_0004, w);
    chk("t2_wait1", w, 0);
    fetch("t2_accept2", 32'h0000_0008, w);
    chk("t2_wait2", w, 2);
    drain("t2_drain");

    // AR backpressure holds the address and blocks the next request.
    ar_en = 1'b0;
    fetch("t3_accept0", 32'h0000_0100, w);
    inst_req = 1'b1; inst_addr = 32'h0000_0104;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_blocked", {31'd0, last_ok}, 32'd0);
      chk("t3_araddr", araddr, 32'h0000_0100);
    end
    ar_en = 1'b1;
    cycle();
    chk("t3_accept_on_ready", {31'd0, last_ok}, 32'd1);
    drain("t3_drain");

    // Cancel with two outstanding and no beat in the cancel cycle.
    lat = 4;
    fetch("t4_accept0", 32'h0000_0200, w);
    fetch("t4_accept1", 32'h0000_0204, w);
    inst_cancel = 1'b1;
    cycle();
    inst_cancel = 1'b0;
    d0 = n_dok;
    fetch("t4_accept_new", 32'hBFC0_0380, w);
    drain("t4_drain");
    chk("t4_live_responses", n_dok - d0, 1);

    // Cancel coincident with a beat; exactly one further beat is dropped.
    lat = 2;
    fetch("t5_accept0", 32'h0000_0300, w);
    fetch("t5_accept1", 32'h0000_0304, w);
    cycle();
    d0 = n_dok;
    inst_req = 1'b1; inst_addr = 32'h0000_0308; inst_cancel = 1'b1;
    cycle();
    chk("t5_ok_in_cancel", {31'd0, last_ok}, 32'd0);
    inst_cancel = 1'b0;
    fetch("t5_accept_new", 32'h0000_0308, w);
    drain("t5_drain");
    chk("t5_live_responses", n_dok - d0, 1);

    // Write requests are never accepted.
    inst_req = 1'b1; inst_wr = 1'b1; inst_addr = 32'h0000_0400;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_wr_addr_ok", {31'd0, last_ok}, 32'd0);
      chk("t6_wr_arvalid", {31'd0, arvalid}, 32'd0);
    end
    inst_req = 1'b0; inst_wr = 1'b0;

    // Reset while one request is in flight.
    lat = 4;
    fetch("t7_accept", 32'h0000_0440, w);
    cycle();
    ar_en = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    rq.delete();
    cycle();
    chk("t7_arvalid", {31'd0, arvalid}, 32'd0);
    chk("t7_araddr", araddr, 32'd0);
    chk("t7_arsize", {29'd0, arsize}, 32'd0);
    chk("t7_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("t7_rdata", inst_rdata, 32'd0);
    chk("t7_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    reset = 1'b0;
    ar_en = 1'b1;
    d0 = n_dok;
    fetch("t7_accept_after", 32'h0000_0500, w);
    fetch("t7_accept_after2", 32'h0000_0504, w);
    drain("t7_drain");
    chk("t7_live_responses", n_dok - d0, 2);

    // Random traffic with occasional cancels, writes and AR stalls.
    lat = 3;
    for (int i = 0; i < 300; i++) begin
      ar_en       = ($urandom_range(0, 3) != 0);
      inst_req    = ($urandom_range(0, 9) < 7);
      inst_wr     = ($urandom_range(0, 9) == 0);
      inst_cancel = ($urandom_range(0, 19) == 0);
      inst_addr   = $urandom & 32'hFFFF_FFFC;
      cycle();
    end
    ar_en = 1'b1;
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
